sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Two-requester arbiter for one single-port buffer SRAM (ib/wb/ob) shared by the matrix-mult engine (requester 0) and the external/host loader (requester 1).
- It replaces the static ext_en mux in front of each buffer, so the host can preload or read back while the array runs.
- Provides round-robin arbitration with burst lock, a forced-external override, 1-cycle read-response routing, and contention statistics.

Parameters:
- DATA_WIDTH, 64, SRAM word width (COL*WIDTH).
- DEPTH, 256, SRAM words; address width AW = $clog2(DEPTH).
- MAX_BURST, 16, maximum consecutive locked grants while the other requester waits (>=1).
- CNT_WIDTH, 16, width of the stall counters.

Ports:
- clk_i  in  1  clock; SRAM samples on posedge.
- rst_async_i  in  1  asynchronous active-high reset.
- force_ext_i  in  1  requester 1 exclusive owner; requester 0 never granted.
- req_i  in  2  per-requester access request, held until granted.
- lock_i  in  2  per-requester burst lock, qualified by own req.
- we_i  in  2  per-requester write (1) / read (0).
- addr_i  in  2*AW  per-requester address, packed [r][AW].
- wdata_i  in  2*DATA_WIDTH  per-requester write data.
- gnt_o  out  2  one-hot-or-zero grant; access happens this cycle.
- rvalid_o  out  2  read data valid for requester r.
- rdata_o  out  DATA_WIDTH  read data, shared bus, qualified by rvalid_o.
- mem_cenb_o  out  1  SRAM chip enable, active low.
- mem_wenb_o  out  1  SRAM write enable, active low.
- mem_addr_o  out  AW  SRAM address.
- mem_d_o  out  DATA_WIDTH  SRAM write data.
- mem_q_i  in  DATA_WIDTH  SRAM read data, valid the cycle after a read access.
- stall_cnt_o  out  2*CNT_WIDTH  per-requester count of cycles with req=1 and gnt=0; saturating.

Behaviour:
- Reset (async assert, sync release):
  - last_owner=1, so requester 0 wins first; burst_cnt=0; owner_locked=0; stall counters 0; rvalid pipe 0.
  - While in reset: gnt_o=0, rvalid_o=0, mem_cenb_o=1, mem_wenb_o=1, mem_addr_o=0, mem_d_o=0, rdata_o passes mem_q_i.
- Grant (combinational from registered state and current req):
  - force_ext_i=1: gnt=req[1]&~0, i.e. gnt[1]=req[1], gnt[0]=0.
  - Else if owner_locked, owner still requesting with lock, and (other not requesting or burst_cnt<MAX_BURST): grant owner.
  - Else if exactly one requester asserts req: grant it.
  - Else if both request: grant ~last_owner (round robin).
- SRAM drive:
  - Granted r: mem_cenb_o=0, mem_wenb_o=~we_i[r], mem_addr_o=addr_i[r], mem_d_o=wdata_i[r].
  - No grant: mem_cenb_o=1, mem_wenb_o=1; addr/data hold the last granted value (no toggling).
- Registered update on each grant to r:
  - last_owner<=r.
  - If lock_i[r] and r==previous owner and owner_locked: burst_cnt<=burst_cnt+1, else burst_cnt<=1.
  - owner_locked<=lock_i[r].
  - No grant: owner_locked<=0, burst_cnt<=0.
- Burst release: when burst_cnt==MAX_BURST and the other requester is waiting, the lock is broken. The other requester is granted next, and burst_cnt restarts at 1 for it.
- Read return:
  - rd_pipe[r]<=gnt[r]&~we_i[r]; rvalid_o=rd_pipe (exactly 1 cycle after the grant).
  - rdata_o=mem_q_i (combinational).
  - Back-to-back reads from alternating requesters return in grant order with no bubble.
- Write-then-read, same address, consecutive grants: the read returns the new data (SRAM write-first).
- Stall counters: increment when req_i[r]&~gnt_o[r]; saturate at all-ones; never wrap.
- force_ext_i toggle mid-burst:
  - On assertion, the next cycle grants only requester 1.
  - Requester 0 lock state is cleared.
  - An in-flight rvalid still completes.
- Reset mid-read: rd_pipe cleared; no rvalid after reset release.
- Requesters must hold req/we/addr/wdata stable until granted; the arbiter does not register requests.

Test Plan:
- Single requester: req0 read at addr 5 (mem[5]=0xA5) -> gnt0 same cycle, mem_cenb_o=0, mem_wenb_o=1, rvalid_o=2'b01 next cycle, rdata=0xA5.
- Contention, no lock: both req continuously, reads of distinct addresses -> grants alternate 0,1,0,1; each rvalid targets the matching requester; stall_cnt increments by 1 every 2 cycles for each.
- Burst lock, MAX_BURST=4: req0+lock0 for 10 writes while req1 waits -> 4 grants to 0, then 1 grant to 1, then 4 grants to 0; stall_cnt[1]=8 by the end.
- force_ext_i=1 with both requesting -> only gnt1 ever asserts; stall_cnt[0] increments every cycle; deassert -> round robin resumes.
- Write addr 7 = 0x1234 via req1, then req0 read addr 7 the next cycle -> rvalid_o[0]=1 with rdata=0x1234.
- Async reset asserted one cycle after a read grant -> rvalid_o stays 0; mem_cenb_o=1; counters 0. After release, first contention grants requester 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter in front of one single-port buffer SRAM (matrix engine = 0, host loader = 1).
// Latency: grant and SRAM drive are combinational in the request cycle; read data returns one cycle later.
// Backpressure: a requester holds req/we/addr/wdata until gnt_o; losers are stalled and counted.
//
// Ports:
//   clk_i, rst_async_i       clock, asynchronous active-high reset (release expected synchronous)
//   force_ext_i              requester 1 owns the SRAM exclusively
//   req_i/lock_i/we_i        per-requester request, burst lock, write(1)/read(0)
//   addr_i/wdata_i           per-requester address/write data, packed [r]
//   gnt_o                    one-hot-or-zero grant, access happens this cycle
//   rvalid_o/rdata_o         read return, one cycle after a read grant; rdata is a shared bus
//   mem_cenb_o/mem_wenb_o    SRAM chip/write enables, active low
//   mem_addr_o/mem_d_o       SRAM address/write data, held when idle
//   mem_q_i                  SRAM read data
//   stall_cnt_o              per-requester saturating count of waiting cycles, packed [r]
module sram_port_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 256,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_async_i,
  input  logic                    force_ext_i,
  input  logic [1:0]              req_i,
  input  logic [1:0]              lock_i,
  input  logic [1:0]              we_i,
  input  logic [2*AW-1:0]         addr_i,
  input  logic [2*DATA_WIDTH-1:0] wdata_i,
  output logic [1:0]              gnt_o,
  output logic [1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    mem_cenb_o,
  output logic                    mem_wenb_o,
  output logic [AW-1:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_d_o,
  input  logic [DATA_WIDTH-1:0]   mem_q_i,
  output logic [2*CNT_WIDTH-1:0]  stall_cnt_o
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]        BURST_MAX = BW'(MAX_BURST);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  // Per-requester views of the packed request buses
  logic [AW-1:0]         addr_r  [2];
  logic [DATA_WIDTH-1:0] wdata_r [2];
  assign addr_r[0]  = addr_i[AW-1:0];
  assign addr_r[1]  = addr_i[2*AW-1:AW];
  assign wdata_r[0] = wdata_i[DATA_WIDTH-1:0];
  assign wdata_r[1] = wdata_i[2*DATA_WIDTH-1:DATA_WIDTH];

  // Registered arbitration state
  logic                  last_owner_q,   last_owner_d;
  logic [BW-1:0]         burst_cnt_q,    burst_cnt_d;
  logic                  owner_locked_q, owner_locked_d;
  logic [1:0]            rd_pipe_q,      rd_pipe_d;
  logic [AW-1:0]         addr_q,         addr_d;
  logic [DATA_WIDTH-1:0] dat_q,          dat_d;
  logic [CNT_WIDTH-1:0]  stall0_q,       stall0_d;
  logic [CNT_WIDTH-1:0]  stall1_q,       stall1_d;

  logic [1:0] gnt;
  logic       gnt_any;
  logic       sel;
  logic       hold_ok;

  // The locked owner keeps the port unless the other side is waiting and the
  // burst budget is spent.
  assign hold_ok = owner_locked_q && req_i[last_owner_q] && lock_i[last_owner_q] &&
                   (!req_i[~last_owner_q] || (burst_cnt_q < BURST_MAX));

  always_comb begin
    gnt = 2'b00;
    if (rst_async_i) begin
      gnt = 2'b00;
    end else if (force_ext_i) begin
      gnt = {req_i[1], 1'b0};
    end else if (hold_ok) begin
      gnt = last_owner_q ? 2'b10 : 2'b01;
    end else begin
      case (req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_owner_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign gnt_any = |gnt;
  assign sel     = gnt[1];

  // SRAM drive; address/data park on the last granted value to avoid toggling
  assign gnt_o      = gnt;
  assign mem_cenb_o = ~gnt_any;
  assign mem_wenb_o = gnt_any ? ~we_i[sel] : 1'b1;
  assign mem_addr_o = gnt_any ? addr_r[sel]  : addr_q;
  assign mem_d_o    = gnt_any ? wdata_r[sel] : dat_q;

  assign rvalid_o    = rd_pipe_q;
  assign rdata_o     = mem_q_i;
  assign stall_cnt_o = {stall1_q, stall0_q};

  always_comb begin
    last_owner_d   = last_owner_q;
    burst_cnt_d    = burst_cnt_q;
    owner_locked_d = owner_locked_q;
    addr_d         = addr_q;
    dat_d          = dat_q;
    rd_pipe_d      = gnt & ~we_i;
    stall0_d       = stall0_q;
    stall1_d       = stall1_q;

    if (gnt_any) begin
      last_owner_d   = sel;
      owner_locked_d = lock_i[sel];
      addr_d         = addr_r[sel];
      dat_d          = wdata_r[sel];
      // Saturate at the budget: an uncontested owner may stay locked indefinitely
      // and the counter must not wrap back under the limit.
      if (lock_i[sel] && (sel == last_owner_q) && owner_locked_q) begin
        burst_cnt_d = (burst_cnt_q == BURST_MAX) ? burst_cnt_q : burst_cnt_q + 1'b1;
      end else begin
        burst_cnt_d = BW'(1);
      end
    end else begin
      owner_locked_d = 1'b0;
      burst_cnt_d    = '0;
    end

    if (req_i[0] && !gnt[0] && (stall0_q != CNT_MAX)) stall0_d = stall0_q + 1'b1;
    if (req_i[1] && !gnt[1] && (stall1_q != CNT_MAX)) stall1_d = stall1_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      last_owner_q   <= 1'b1;  // requester 0 wins the first contention
      burst_cnt_q    <= '0;
      owner_locked_q <= 1'b0;
      rd_pipe_q      <= 2'b00;
      addr_q         <= '0;
      dat_q          <= '0;
      stall0_q       <= '0;
      stall1_q       <= '0;
    end else begin
      last_owner_q   <= last_owner_d;
      burst_cnt_q    <= burst_cnt_d;
      owner_locked_q <= owner_locked_d;
      rd_pipe_q      <= rd_pipe_d;
      addr_q         <= addr_d;
      dat_q          <= dat_d;
      stall0_q       <= stall0_d;
      stall1_q       <= stall1_d;
    end
  end

endmodule
